// File: rtl/mult_sched_pkg.sv
// Shared types for the multiplier job scheduler: job and result records,
// the requester id type and the truncating 64x64 product helper.
package mult_sched_pkg;

  localparam int PROD_W   = 64;
  localparam int ADDR_W   = 42;
  localparam int ID_MAX_W = 8;

  typedef logic [ID_MAX_W-1:0] t_req_id;

  typedef struct packed {
    logic [PROD_W-1:0] a;
    logic [PROD_W-1:0] b;
    logic [ADDR_W-1:0] addr;
    t_req_id           id;
  } t_job;

  typedef struct packed {
    logic [PROD_W-1:0] prod;
    logic [ADDR_W-1:0] addr;
    t_req_id           id;
  } t_result;

  // Unsigned product truncated to the low PROD_W bits.
  function automatic logic [PROD_W-1:0] mul_lo(input logic [PROD_W-1:0] a,
                                               input logic [PROD_W-1:0] b);
    logic [2*PROD_W-1:0] full;
    full = {{PROD_W{1'b0}}, a} * {{PROD_W{1'b0}}, b};
    return full[PROD_W-1:0];
  endfunction

endpackage

// File: rtl/mult_job_sched_mult_pipe.sv
// MUL_LAT-stage multiplier: the accept cycle is stage 0, followed by MUL_LAT-1
// registered stages; the result buffer write completes the last stage.
module mult_pipe
  import mult_sched_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = $clog2(MUL_LAT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  t_job             in_job,
  output logic             out_valid,
  output t_result          out_res,
  output logic [CNT_W-1:0] n_valid
);

  t_result head_s;

  // Stage 0: form the product and carry the sidebands.
  always_comb begin
    head_s.prod = mul_lo(in_job.a, in_job.b);
    head_s.addr = in_job.addr;
    head_s.id   = in_job.id;
  end

  if (MUL_LAT == 1) begin : g_comb
    assign out_valid = in_valid;
    assign out_res   = head_s;
    assign n_valid   = '0;
  end else begin : g_regs
    localparam int NS = MUL_LAT - 1;
    logic [NS-1:0] vld_r;
    t_result       stg_r [NS];

    // Valid shift chain; reset drops every in-flight job.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_r <= '0;
      end else begin
        vld_r[0] <= in_valid;
        for (int k = 1; k < NS; k++) vld_r[k] <= vld_r[k-1];
      end
    end

    // Data stages carry no reset; only the valids qualify them.
    always_ff @(posedge clk) begin
      stg_r[0] <= head_s;
      for (int k = 1; k < NS; k++) stg_r[k] <= stg_r[k-1];
    end

    // Occupied-stage count feeds the credit check.
    always_comb begin
      n_valid = '0;
      for (int k = 0; k < NS; k++) n_valid = n_valid + CNT_W'(vld_r[k]);
    end

    assign out_valid = vld_r[NS-1];
    assign out_res   = stg_r[NS-1];
  end

endmodule

// File: rtl/mult_job_sched.sv
// Round-robin scheduler sharing one pipelined multiplier and the c1 write path
// among N_REQ requesters; results are buffered in order and drained when !almfull.
module mult_job_sched
  import mult_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MUL_LAT    = 3,
  parameter int RBUF_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ-1:0][PROD_W-1:0]     req_a,
  input  logic [N_REQ-1:0][PROD_W-1:0]     req_b,
  input  logic [N_REQ-1:0][ADDR_W-1:0]     req_addr,
  input  logic                             wr_almfull,
  output logic                             wr_valid,
  output logic [ADDR_W-1:0]                wr_addr,
  output logic [PROD_W-1:0]                wr_data,
  output logic                             done_valid,
  output logic [$clog2(N_REQ)-1:0]         done_id,
  output logic                             busy
);

  localparam int ID_W   = $clog2(N_REQ);
  localparam int PTR_W  = $clog2(RBUF_DEPTH);
  localparam int CNT_W  = $clog2(RBUF_DEPTH + 1);
  localparam int PCNT_W = $clog2(MUL_LAT + 1);
  localparam int OUT_W  = $clog2(MUL_LAT + RBUF_DEPTH + 1);

  logic [ID_W-1:0]   rr_ptr_r;
  logic [N_REQ-1:0]  grant_s;
  logic [ID_W-1:0]   gnt_idx_s;
  logic              gnt_any_s;
  logic              credit_ok_s;
  logic [OUT_W-1:0]  outstanding_s;
  t_job              job_s;

  logic              pipe_valid_s;
  t_result           pipe_res_s;
  logic [PCNT_W-1:0] pipe_cnt_s;

  t_result           buf_r [RBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              push_s;
  logic              pop_s;
  t_result           head_s;

  logic              wr_valid_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [PROD_W-1:0] wr_data_r;
  logic [ID_W-1:0]   done_id_r;

  // Every job in the pipe already owns a buffer slot, so the buffer cannot overflow.
  always_comb begin
    outstanding_s = OUT_W'(pipe_cnt_s) + OUT_W'(cnt_r);
    credit_ok_s   = !reset && (outstanding_s < OUT_W'(RBUF_DEPTH));
  end

  // Round-robin search starting at the pointer, gated by credit.
  always_comb begin
    int idx;
    grant_s   = '0;
    gnt_idx_s = '0;
    gnt_any_s = 1'b0;
    idx       = 0;
    if (credit_ok_s) begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (int'(rr_ptr_r) + k) % N_REQ;
        if (!gnt_any_s && req_valid[idx]) begin
          gnt_any_s    = 1'b1;
          gnt_idx_s    = ID_W'(idx);
          grant_s[idx] = 1'b1;
        end else begin
          gnt_any_s = gnt_any_s;
        end
      end
    end else begin
      grant_s = '0;
    end
  end

  assign req_ready = grant_s;

  // Granted requester's operands into the multiplier.
  always_comb begin
    job_s.a    = req_a[gnt_idx_s];
    job_s.b    = req_b[gnt_idx_s];
    job_s.addr = req_addr[gnt_idx_s];
    job_s.id   = t_req_id'(gnt_idx_s);
  end

  // Pointer moves past the winner; holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_r <= '0;
    end else if (gnt_any_s) begin
      rr_ptr_r <= (gnt_idx_s == ID_W'(N_REQ - 1)) ? '0 : gnt_idx_s + ID_W'(1);
    end
  end

  mult_pipe #(.MUL_LAT(MUL_LAT), .CNT_W(PCNT_W)) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (gnt_any_s),
    .in_job    (job_s),
    .out_valid (pipe_valid_s),
    .out_res   (pipe_res_s),
    .n_valid   (pipe_cnt_s)
  );

  always_comb begin
    push_s = pipe_valid_s;
    pop_s  = (cnt_r != '0) && !wr_almfull;
    head_s = buf_r[rd_ptr_r];
  end

  // Result FIFO storage; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (push_s) buf_r[wr_ptr_r] <= pipe_res_s;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Registered write request; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid_r <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= '0;
      done_id_r  <= '0;
    end else begin
      wr_valid_r <= pop_s;
      if (pop_s) begin
        wr_addr_r <= head_s.addr;
        wr_data_r <= head_s.prod;
        done_id_r <= ID_W'(head_s.id);
      end
    end
  end

  assign wr_valid   = wr_valid_r;
  assign done_valid = wr_valid_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign done_id    = done_id_r;
  assign busy       = (outstanding_s != '0) || wr_valid_r;

endmodule

// File: tb/tb_mult_job_sched.sv
// Directed self-checking bench for mult_job_sched (N_REQ=4, MUL_LAT=3, RBUF_DEPTH=4).
module tb_mult_job_sched;

  typedef struct packed { logic [63:0] a; logic [63:0] b; logic [41:0] addr; } job_t;
  typedef struct packed { logic [1:0] id; logic [31:0] cyc; } gnt_t;
  typedef struct packed { logic [63:0] d; logic [41:0] addr; logic [1:0] id; } exp_t;
  typedef struct packed { logic [63:0] d; logic [41:0] addr; logic [1:0] id; logic [31:0] cyc; } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        req_valid;
  logic [3:0]        req_ready;
  logic [3:0][63:0]  req_a;
  logic [3:0][63:0]  req_b;
  logic [3:0][41:0]  req_addr;
  logic              wr_almfull;
  logic              wr_valid;
  logic [41:0]       wr_addr;
  logic [63:0]       wr_data;
  logic              done_valid;
  logic [1:0]        done_id;
  logic              busy;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] cyc    = 32'd0;

  job_t jq [4][$];
  gnt_t gq [$];
  exp_t eq [$];
  wr_t  wq [$];

  mult_job_sched #(.N_REQ(4), .MUL_LAT(3), .RBUF_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_addr   (req_addr),
    .wr_almfull (wr_almfull),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .done_valid (done_valid),
    .done_id    (done_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: logs every write and scores it against the acceptance-order model.
  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      wq.push_back('{d: wr_data, addr: wr_addr, id: done_id, cyc: cyc});
      chk("done_valid", 64'(done_valid), 64'd1);
      chk("unexpected_write", 64'(eq.size() > 0), 64'd1);
      if (eq.size() > 0) begin
        chk("sb_data", wr_data, eq[0].d);
        chk("sb_addr", 64'(wr_addr), 64'(eq[0].addr));
        chk("sb_id", 64'(done_id), 64'(eq[0].id));
        void'(eq.pop_front());
      end
    end
  end

  task automatic load(input int i);
    job_t j;
    if (jq[i].size() > 0) begin
      j = jq[i].pop_front();
      req_a[i] = j.a; req_b[i] = j.b; req_addr[i] = j.addr; req_valid[i] = 1'b1;
    end else begin
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic step();
    logic [3:0] acc;
    @(negedge clk);
    chk("grant_onehot", 64'($onehot0(req_ready)), 64'd1);
    chk("grant_only_valid", 64'(req_ready & ~req_valid), 64'd0);
    acc = req_valid & req_ready;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        gq.push_back('{id: 2'(i), cyc: cyc});
        eq.push_back('{d: req_a[i] * req_b[i], addr: req_addr[i], id: 2'(i)});
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) if (acc[i]) load(i);
  endtask

  task automatic run_idle(input int max);
    int n = 0;
    while ((busy || req_valid != 4'd0) && n < max) begin
      step();
      n++;
    end
    chk("idle_timeout", 64'(n < max), 64'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 4'd0;
    for (int i = 0; i < 4; i++) jq[i].delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    gq.delete(); eq.delete(); wq.delete();
  endtask

  initial begin
    reset = 1'b1; req_valid = 4'hF; req_a = '0; req_b = '0; req_addr = '0; wr_almfull = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_done_valid", 64'(done_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_done_id", 64'(done_id), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    do_reset();

    // 1: single job on requester 2
    jq[2].push_back('{a: 64'd6, b: 64'd7, addr: 42'h1000});
    load(2);
    run_idle(50);
    chk("t1_nwrites", 64'(wq.size()), 64'd1);
    chk("t1_ngrants", 64'(gq.size()), 64'd1);
    if (wq.size() == 1 && gq.size() == 1) begin
      chk("t1_data", wq[0].d, 64'd42);
      chk("t1_addr", 64'(wq[0].addr), 64'h1000);
      chk("t1_id", 64'(wq[0].id), 64'd2);
      chk("t1_latency", 64'(wq[0].cyc - gq[0].cyc), 64'd4);
    end
    chk("t1_busy_low", 64'(busy), 64'd0);

    // 2: all four requesters, three jobs each, fresh pointer
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 3; r++)
        jq[i].push_back('{a: 64'(i + 1), b: 64'd10, addr: 42'(16 * i + r)});
    for (int i = 0; i < 4; i++) load(i);
    run_idle(100);
    chk("t2_ngrants", 64'(gq.size()), 64'd12);
    chk("t2_nwrites", 64'(wq.size()), 64'd12);
    if (gq.size() == 12 && wq.size() == 12) begin
      for (int k = 0; k < 12; k++) begin
        chk("t2_grant_id", 64'(gq[k].id), 64'(k % 4));
        chk("t2_grant_cycle", 64'(gq[k].cyc - gq[0].cyc), 64'(k));
        chk("t2_wr_id", 64'(wq[k].id), 64'(k % 4));
        chk("t2_wr_data", wq[k].d, 64'((k % 4 + 1) * 10));
        chk("t2_wr_cycle", 64'(wq[k].cyc - wq[0].cyc), 64'(k));
      end
    end

    // 3: almfull high blocks draining; credit stops acceptance at four
    gq.delete(); wq.delete();
    wr_almfull = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 2; r++)
        jq[i].push_back('{a: 64'(100 + i), b: 64'(3 + r), addr: 42'(256 + 4 * i + r)});
    for (int i = 0; i < 4; i++) load(i);
    repeat (12) step();
    chk("t3_accepted", 64'(gq.size()), 64'd4);
    chk("t3_no_write", 64'(wq.size()), 64'd0);
    chk("t3_ready_low", 64'(req_ready), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
    wr_almfull = 1'b0;
    run_idle(100);
    chk("t3_total_grants", 64'(gq.size()), 64'd8);
    chk("t3_total_writes", 64'(wq.size()), 64'd8);
    if (wq.size() >= 4)
      for (int k = 1; k < 4; k++) chk("t3_b2b", 64'(wq[k].cyc - wq[0].cyc), 64'(k));

    // 4/5: truncation and zero operand, both from requester 1
    gq.delete(); wq.delete();
    jq[1].push_back('{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd2, addr: 42'h3FF_0000_0001});
    jq[1].push_back('{a: 64'd0, b: 64'd5, addr: 42'h2000});
    load(1);
    run_idle(50);
    chk("t45_nwrites", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk("t4_data", wq[0].d, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("t4_addr", 64'(wq[0].addr), 64'h3FF_0000_0001);
      chk("t5_data", wq[1].d, 64'd0);
      chk("t5_addr", 64'(wq[1].addr), 64'h2000);
    end

    // 6: reset with jobs in both pipe and buffer
    gq.delete(); wq.delete();
    wr_almfull = 1'b1;
    for (int i = 1; i < 4; i++)
      for (int r = 0; r < 2; r++)
        jq[i].push_back('{a: 64'(i), b: 64'(7 + r), addr: 42'(512 + 2 * i + r)});
    for (int i = 1; i < 4; i++) load(i);
    repeat (4) step();
    chk("t6_pre_grants", 64'(gq.size()), 64'd4);
    chk("t6_pre_busy", 64'(busy), 64'd1);
    reset = 1'b1; req_valid = 4'd0; wr_almfull = 1'b0;
    for (int i = 0; i < 4; i++) jq[i].delete();
    @(posedge clk); #1;
    reset = 1'b0;
    gq.delete(); eq.delete();
    chk("t6_busy_after", 64'(busy), 64'd0);
    chk("t6_wr_valid_after", 64'(wr_valid), 64'd0);
    repeat (8) step();
    chk("t6_no_write", 64'(wq.size()), 64'd0);
    jq[0].push_back('{a: 64'd9, b: 64'd9, addr: 42'h40});
    jq[3].push_back('{a: 64'd4, b: 64'd4, addr: 42'h43});
    load(0); load(3);
    step();
    chk("t6_ngrant", 64'(gq.size()), 64'd1);
    if (gq.size() >= 1) chk("t6_first_grant", 64'(gq[0].id), 64'd0);
    run_idle(50);
    chk("t6_nwrites", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk("t6_data0", wq[0].d, 64'd81);
      chk("t6_data1", wq[1].d, 64'd16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
